// File: rtl/gr_file_mp_pkg.sv
// Shared CPU register-file definitions: default width, register index type, zero register.
package lib_cpu;

   localparam int unsigned XLEN_DEFAULT = 32;
   localparam int unsigned NREG_DEFAULT = 16;
   localparam int unsigned REG_IDX_W    = $clog2(NREG_DEFAULT);

   typedef logic [REG_IDX_W-1:0] reg_idx_t;

   // Register 0 reads as zero and ignores writes and claims.
   localparam reg_idx_t REG_ZERO = '0;

endpackage : lib_cpu

// File: rtl/gr_file_mp_scoreboard.sv
// Write-pending scoreboard: one busy flop per register, ordered flush/write/claim
// update, registered population count and an unclaimed-write diagnostic pulse.
module gr_scoreboard
   import lib_cpu::*;
#(
   parameter  int unsigned NREG = 16,
   localparam int unsigned AW   = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [NREG-1:0] wr_hit,
   input  logic            claim_en,
   input  logic [AW-1:0]   claim_addr,
   input  logic            flush,
   output logic [NREG-1:0] busy,
   output logic [AW:0]     busy_cnt,
   output logic            wr_unclaimed
);

   localparam int unsigned CW = AW + 1;

   logic [NREG-1:0] busy_nxt;
   logic [AW:0]     cnt_nxt;
   logic            unc_nxt;

   // Next busy vector: flush clears, writes clear, a claim then sets (claim wins).
   always_comb begin
      busy_nxt = busy;
      if (flush) begin
         busy_nxt = '0;
      end
      busy_nxt = busy_nxt & ~wr_hit;
      if (claim_en && (claim_addr != AW'(REG_ZERO))) begin
         busy_nxt[claim_addr] = 1'b1;
      end
   end

   // Population count of the next busy vector, registered alongside it.
   always_comb begin
      cnt_nxt = '0;
      for (int unsigned r = 0; r < NREG; r++) begin
         cnt_nxt = cnt_nxt + CW'(busy_nxt[r]);
      end
   end

   // A write landing on a register that was not pending, unless squashed by flush.
   always_comb begin
      unc_nxt = !flush && (|(wr_hit & ~busy));
   end

   // Scoreboard state registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy         <= '0;
         busy_cnt     <= '0;
         wr_unclaimed <= 1'b0;
      end else begin
         busy         <= busy_nxt;
         busy_cnt     <= cnt_nxt;
         wr_unclaimed <= unc_nxt;
      end
   end

endmodule : gr_scoreboard

// File: rtl/gr_file_mp.sv
// Multi-port general-register file with write-pending scoreboard and optional
// same-cycle write-to-read bypass. Register 0 is hardwired to zero.
module gr_file_mp
   import lib_cpu::*;
#(
   parameter  int unsigned XLEN   = XLEN_DEFAULT,
   parameter  int unsigned NREG   = 16,
   parameter  int unsigned NRP    = 2,
   parameter  int unsigned NWP    = 2,
   parameter  int unsigned BYPASS = 1,
   localparam int unsigned AW     = $clog2(NREG)
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [NRP*AW-1:0]   rp_addr,
   output logic [NRP*XLEN-1:0] rp_data,
   output logic [NRP-1:0]      rp_busy,
   input  logic [NWP-1:0]      wp_en,
   input  logic [NWP*AW-1:0]   wp_addr,
   input  logic [NWP*XLEN-1:0] wp_data,
   input  logic                claim_en,
   input  logic [AW-1:0]       claim_addr,
   input  logic                flush,
   output logic [AW:0]         busy_cnt,
   output logic                wr_unclaimed
);

   logic [XLEN-1:0] regs   [NREG];
   logic [XLEN-1:0] wr_val [NREG];
   logic [NREG-1:0] wr_hit;
   logic [NREG-1:0] busy;

   // Per-register write select; later ports override earlier ones, address 0 never hits.
   always_comb begin
      wr_hit = '0;
      for (int unsigned r = 0; r < NREG; r++) begin
         wr_val[r] = '0;
         for (int unsigned w = 0; w < NWP; w++) begin
            if (wp_en[w] && (wp_addr[w*AW +: AW] == AW'(r)) &&
                (wp_addr[w*AW +: AW] != AW'(REG_ZERO))) begin
               wr_hit[r] = 1'b1;
               wr_val[r] = wp_data[w*XLEN +: XLEN];
            end
         end
      end
   end

   // Register array storage.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned r = 0; r < NREG; r++) begin
            regs[r] <= '0;
         end
      end else begin
         for (int unsigned r = 0; r < NREG; r++) begin
            if (wr_hit[r]) begin
               regs[r] <= wr_val[r];
            end
         end
      end
   end

   // Combinational read ports: stored value, optional bypass with the same priority, r0 forced to 0.
   always_comb begin
      rp_data = '0;
      rp_busy = '0;
      for (int unsigned p = 0; p < NRP; p++) begin
         logic [AW-1:0]   a;
         logic [XLEN-1:0] d;
         a = rp_addr[p*AW +: AW];
         d = regs[a];
         if (BYPASS != 0) begin
            for (int unsigned w = 0; w < NWP; w++) begin
               if (wp_en[w] && (wp_addr[w*AW +: AW] == a)) begin
                  d = wp_data[w*XLEN +: XLEN];
               end
            end
         end
         if (a == AW'(REG_ZERO)) begin
            d = '0;
         end
         rp_data[p*XLEN +: XLEN] = d;
         rp_busy[p]              = busy[a] && (a != AW'(REG_ZERO));
      end
   end

   gr_scoreboard #(
      .NREG (NREG)
   ) u_sb (
      .clk          (clk),
      .reset_n      (reset_n),
      .wr_hit       (wr_hit),
      .claim_en     (claim_en),
      .claim_addr   (claim_addr),
      .flush        (flush),
      .busy         (busy),
      .busy_cnt     (busy_cnt),
      .wr_unclaimed (wr_unclaimed)
   );

endmodule : gr_file_mp
